// File: rtl/adsr_env.sv
// -----------------------------------------------------------------------------
// adsr_env
//   ADSR envelope generator feeding the amplitude multiplier's signed ctrl
//   input. A rising gate starts (or retriggers) the envelope and a low gate
//   sends it to release. The level is stepped once per sample_en strobe and is
//   clamped to 0..2^(WIDTH-1)-1, so env_out never goes negative and never wraps.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   sample_en     one-clk strobe per audio sample; the envelope steps only on it
//   gate          note gate, level-sensitive, sampled every clk
//   attack_rate   unsigned increment per tick in ATTACK
//   decay_rate    unsigned decrement per tick in DECAY
//   sustain_lvl   unsigned sustain level, followed live while in SUSTAIN
//   release_rate  unsigned decrement per tick in RELEASE
//   env_out       registered signed gain {1'b0, level}
//   state         0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   busy          1 whenever state != IDLE
//   done          one-clk pulse on the RELEASE -> IDLE transition
// -----------------------------------------------------------------------------
module adsr_env #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             gate,
  input  logic [WIDTH-2:0] attack_rate,
  input  logic [WIDTH-2:0] decay_rate,
  input  logic [WIDTH-2:0] sustain_lvl,
  input  logic [WIDTH-2:0] release_rate,
  output logic [WIDTH-1:0] env_out,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  localparam int M = WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [M-1:0] LEVEL_MAX = '1;

  state_t       state_q;
  logic [M-1:0] level;
  logic         gate_d;
  logic         armed;
  logic         rise;
  logic         gate_low_active;
  logic [M:0]   atk_sum;
  logic [M:0]   dec_floor;

  // A gate that is already high when reset lifts must not start a note, so a
  // rising edge only counts once the gate has been seen low after reset.
  assign rise = gate & ~gate_d & armed;

  assign gate_low_active = ~gate &
    ((state_q == ATTACK) || (state_q == DECAY) || (state_q == SUSTAIN));

  // One bit of headroom so the attack sum and decay threshold cannot wrap
  // before they are compared against the limits.
  assign atk_sum   = {1'b0, level} + {1'b0, attack_rate};
  assign dec_floor = {1'b0, sustain_lvl} + {1'b0, decay_rate};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gate_d  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state_q, level and gate_d.
      gate_d <= gate;
      armed  <= armed | ~gate;
      done   <= 1'b0;

      if (rise) begin
        // Retrigger keeps the current level; no step on this clk.
        state_q <= ATTACK;
        busy    <= 1'b1;
      end else if (gate_low_active) begin
        state_q <= RELEASE;
        busy    <= 1'b1;
      end else if (sample_en) begin
        unique case (state_q)
          IDLE: begin
            level <= '0;
          end
          ATTACK: begin
            if (atk_sum >= {1'b0, LEVEL_MAX}) begin
              level   <= LEVEL_MAX;
              state_q <= DECAY;
            end else begin
              level <= atk_sum[M-1:0];
            end
          end
          DECAY: begin
            if ({1'b0, level} <= dec_floor) begin
              level   <= sustain_lvl;
              state_q <= SUSTAIN;
            end else begin
              level <= level - decay_rate;
            end
          end
          SUSTAIN: begin
            level <= sustain_lvl;
          end
          RELEASE: begin
            if (level <= release_rate) begin
              level   <= '0;
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              level <= level - release_rate;
            end
          end
          default: begin
            // Unused encodings fall back to a silent idle.
            level   <= '0;
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign env_out = {1'b0, level};
  assign state   = state_q;

endmodule

// File: tb/tb_adsr_env.sv
// -----------------------------------------------------------------------------
// tb_adsr_env
//   Self-checking bench for adsr_env. Each scenario builds a table of per-clk
//   stimulus vectors carrying the expected outputs. Inputs are driven on the
//   falling edge, the expectation is pushed to a scoreboard queue, and after
//   the next rising edge the outputs are sampled on the falling edge and
//   compared against the popped entry.
// -----------------------------------------------------------------------------
module tb_adsr_env;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic        gate;
  logic [16:0] attack_rate;
  logic [16:0] decay_rate;
  logic [16:0] sustain_lvl;
  logic [16:0] release_rate;
  logic [17:0] env_out;
  logic [2:0]  state;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  typedef struct {
    logic        g;
    logic        se;
    logic [16:0] lvl;
    logic [2:0]  st;
    logic        dn;
  } vec_t;

  vec_t sb[$];

  adsr_env #(.WIDTH(18)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_lvl  (sustain_lvl),
    .release_rate (release_rate),
    .env_out      (env_out),
    .state        (state),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic vec_t mk(input logic g, input logic se,
                              input int unsigned lvl, input logic [2:0] st,
                              input logic dn);
    vec_t v;
    v.g   = g;
    v.se  = se;
    v.lvl = 17'(lvl);
    v.st  = st;
    v.dn  = dn;
    return v;
  endfunction

  // Spec test 1 plus a gate held high across reset.
  task automatic test_reset();
    vec_t stim[$];
    vec_t e;
    reset = 1'b1; gate = 1'b0; sample_en = 1'b0;
    attack_rate = '0; decay_rate = '0; sustain_lvl = '0; release_rate = '0;
    repeat (3) @(negedge clk);
    sb.push_back(mk(1'b0, 1'b0, 0, S_IDLE, 1'b0));
    e = sb.pop_front();
    checks++;
    if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== 1'b0 || done !== e.dn) begin
      errors++;
      $display("FAIL reset_hold: got env=%0d st=%0d busy=%b done=%b, want env=0 st=0 busy=0 done=0",
               env_out, state, busy, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) stim.push_back(mk(1'b0, 1'b1, 0, S_IDLE, 1'b0));
    for (int i = 0; i < 5; i++)  stim.push_back(mk(1'b1, 1'b1, 0, S_IDLE, 1'b0));
    stim.push_back(mk(1'b0, 1'b0, 0, S_IDLE, 1'b0));
    foreach (stim[i]) begin
      if (i == 50) begin
        gate = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL reset[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Spec test 2: full ADSR cycle with sample_en every 4 clk.
  task automatic test_full_envelope();
    vec_t stim[$];
    vec_t e;
    int unsigned lv[8] = '{32768, 65536, 98304, 131071, 114687, 98303, 81919, 65536};
    logic [2:0]  st[8] = '{S_ATK, S_ATK, S_ATK, S_DEC, S_DEC, S_DEC, S_DEC, S_SUS};
    int unsigned prev;
    logic [2:0]  pst;
    attack_rate = 17'd32768; decay_rate = 17'd16384;
    sustain_lvl = 17'd65536; release_rate = 17'd8192;
    stim.push_back(mk(1'b1, 1'b0, 0, S_ATK, 1'b0));
    prev = 0; pst = S_ATK;
    for (int k = 0; k < 8; k++) begin
      repeat (3) stim.push_back(mk(1'b1, 1'b0, prev, pst, 1'b0));
      stim.push_back(mk(1'b1, 1'b1, lv[k], st[k], 1'b0));
      prev = lv[k]; pst = st[k];
    end
    stim.push_back(mk(1'b1, 1'b1, 65536, S_SUS, 1'b0));
    stim.push_back(mk(1'b0, 1'b0, 65536, S_REL, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      repeat (3) stim.push_back(mk(1'b0, 1'b0, 65536 - 8192 * (k - 1), S_REL, 1'b0));
      if (k < 8) stim.push_back(mk(1'b0, 1'b1, 65536 - 8192 * k, S_REL, 1'b0));
      else       stim.push_back(mk(1'b0, 1'b1, 0, S_IDLE, 1'b1));
    end
    stim.push_back(mk(1'b0, 1'b0, 0, S_IDLE, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0, S_IDLE, 1'b0));
    foreach (stim[i]) begin
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL full_env[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Spec test 3: attack clamps at MAX without wrapping; sustain=MAX exits decay at once.
  task automatic test_attack_clamp();
    vec_t stim[$];
    vec_t e;
    attack_rate = 17'd131071; decay_rate = 17'd5;
    sustain_lvl = 17'd131071; release_rate = 17'd131071;
    stim.push_back(mk(1'b1, 1'b0, 0,      S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 131071, S_DEC,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 131071, S_SUS,  1'b0));
    stim.push_back(mk(1'b0, 1'b0, 131071, S_REL,  1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0,      S_IDLE, 1'b1));
    stim.push_back(mk(1'b0, 1'b0, 0,      S_IDLE, 1'b0));
    // 100000 + 100000 would wrap to 68928 in 17 bits; must clamp instead.
    stim.push_back(mk(1'b1, 1'b0, 0,      S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 100000, S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 131071, S_DEC,  1'b0));
    stim.push_back(mk(1'b0, 1'b0, 131071, S_REL,  1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0,      S_IDLE, 1'b1));
    stim.push_back(mk(1'b0, 1'b0, 0,      S_IDLE, 1'b0));
    foreach (stim[i]) begin
      if (i == 6) attack_rate = 17'd100000;
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL clamp[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Spec test 4: retrigger from RELEASE keeps the level, no step on that clk.
  task automatic test_retrigger();
    vec_t stim[$];
    vec_t e;
    attack_rate = 17'd40000; decay_rate = 17'd0;
    sustain_lvl = 17'd0; release_rate = 17'd1000;
    stim.push_back(mk(1'b1, 1'b0, 0,     S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 40000, S_ATK,  1'b0));
    stim.push_back(mk(1'b0, 1'b0, 40000, S_REL,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 40000, S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 80000, S_ATK,  1'b0));
    stim.push_back(mk(1'b0, 1'b0, 80000, S_REL,  1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0,     S_IDLE, 1'b1));
    stim.push_back(mk(1'b0, 1'b0, 0,     S_IDLE, 1'b0));
    foreach (stim[i]) begin
      if (i == 6) release_rate = 17'd131071;
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL retrigger[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Spec test 5: gate falls in ATTACK (with a coincident tick) -> RELEASE from 20000.
  task automatic test_release_from_attack();
    vec_t stim[$];
    vec_t e;
    attack_rate = 17'd20000; decay_rate = 17'd0;
    sustain_lvl = 17'd0; release_rate = 17'd30000;
    stim.push_back(mk(1'b1, 1'b0, 0,     S_ATK,  1'b0));
    stim.push_back(mk(1'b1, 1'b1, 20000, S_ATK,  1'b0));
    stim.push_back(mk(1'b0, 1'b1, 20000, S_REL,  1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0,     S_IDLE, 1'b1));
    stim.push_back(mk(1'b0, 1'b0, 0,     S_IDLE, 1'b0));
    foreach (stim[i]) begin
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL rel_from_atk[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Zero rates: level holds and state does not advance.
  task automatic test_zero_rate();
    vec_t stim[$];
    vec_t e;
    attack_rate = 17'd5000; decay_rate = 17'd0;
    sustain_lvl = 17'd0; release_rate = 17'd0;
    stim.push_back(mk(1'b1, 1'b0, 0,    S_ATK, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 5000, S_ATK, 1'b0));
    repeat (3) stim.push_back(mk(1'b1, 1'b1, 5000, S_ATK, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 5000, S_REL, 1'b0));
    repeat (3) stim.push_back(mk(1'b0, 1'b1, 5000, S_REL, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 0, S_IDLE, 1'b1));
    stim.push_back(mk(1'b0, 1'b0, 0, S_IDLE, 1'b0));
    foreach (stim[i]) begin
      if (i == 2) attack_rate = 17'd0;
      if (i == 9) release_rate = 17'd5000;
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL zero_rate[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  // Spec test 6: live sustain edit, then async reset mid-RELEASE with no done.
  task automatic test_sustain_reset();
    vec_t stim[$];
    vec_t e;
    attack_rate = 17'd131071; decay_rate = 17'd131071;
    sustain_lvl = 17'd65536; release_rate = 17'd100;
    stim.push_back(mk(1'b1, 1'b0, 0,      S_ATK, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 131071, S_DEC, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 65536,  S_SUS, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 65536,  S_SUS, 1'b0));
    stim.push_back(mk(1'b1, 1'b0, 65536,  S_SUS, 1'b0));
    stim.push_back(mk(1'b1, 1'b1, 1000,   S_SUS, 1'b0));
    stim.push_back(mk(1'b0, 1'b0, 1000,   S_REL, 1'b0));
    stim.push_back(mk(1'b0, 1'b1, 900,    S_REL, 1'b0));
    foreach (stim[i]) begin
      if (i == 4) sustain_lvl = 17'd1000;
      gate = stim[i].g; sample_en = stim[i].se;
      sb.push_back(stim[i]);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL sustain[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    // Step 0 checks the asynchronous clear before any clock edge; steps 1-2
    // hold reset over edges; step 3 releases it and ticks in IDLE.
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b0, (i == 3), 0, S_IDLE, 1'b0));
      if (i == 0) begin
        sample_en = 1'b1;
        reset = 1'b1;
        #1;
      end else begin
        if (i == 3) reset = 1'b0;
        sample_en = (i == 3);
        @(posedge clk); @(negedge clk);
      end
      e = sb.pop_front();
      checks++;
      if (env_out !== {1'b0, e.lvl} || state !== e.st || busy !== (e.st != S_IDLE) || done !== e.dn) begin
        errors++;
        $display("FAIL mid_rel_reset[%0d]: got env=%0d st=%0d busy=%b done=%b, want env=%0d st=%0d busy=%b done=%b",
                 i, env_out, state, busy, done, e.lvl, e.st, (e.st != S_IDLE), e.dn);
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_envelope();
    test_attack_clamp();
    test_retrigger();
    test_release_from_attack();
    test_zero_rate();
    test_sustain_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
